// File: rtl/acc_drain.sv
// acc_drain: captures one column of accumulator lanes, requantizes them,
// and serializes the lanes one per cycle onto an AXI-Stream master.
module acc_drain #(
  parameter int R     = 8,
  parameter int WY    = 16,
  parameter int WO    = 8,
  parameter int SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [R*WY-1:0]      s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [WO-1:0] m_data,
  output logic                 m_last
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam logic [IW-1:0] LAST = IW'(R - 1);

  localparam logic signed [WY:0] RND =
    (WY+1)'((1 << SHIFT) >> 1);
  localparam logic signed [WY:0] MAXV =
    (WY+1)'((1 << (WO - 1)) - 1);
  localparam logic signed [WY:0] MINV = ~MAXV;

  typedef enum logic {IDLE, DRAIN} st_t;

  st_t                 st, st_n;
  logic [IW-1:0]       idx, idx_n;
  logic                lst, lst_n;
  logic signed [WO-1:0] obuf [R];
  logic signed [WO-1:0] q [R];
  logic                cap;
  logic                fire;
  logic                at_end;

  // One extra bit keeps the rounding add from wrapping.
  function automatic logic signed [WO-1:0] rq(
    input logic signed [WY-1:0] x
  );
    logic signed [WY:0] t;
    t = ((WY+1)'(x) + RND) >>> SHIFT;
    if (t > MAXV)
      rq = MAXV[WO-1:0];
    else if (t < MINV)
      rq = MINV[WO-1:0];
    else
      rq = t[WO-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < R; i++)
      q[i] = rq(s_data[i*WY +: WY]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st  <= IDLE;
      idx <= '0;
      lst <= 1'b0;
      for (int i = 0; i < R; i++)
        obuf[i] <= '0;
    end else begin
      st  <= st_n;
      idx <= idx_n;
      lst <= lst_n;
      if (cap)
        for (int i = 0; i < R; i++)
          obuf[i] <= q[i];
    end
  end

  always_comb begin
    at_end = (idx == LAST);
    fire   = (st == DRAIN) && m_ready;
    cap    = s_valid &&
             ((st == IDLE) || (fire && at_end));
    st_n   = st;
    idx_n  = idx;
    lst_n  = lst;
    if (cap) begin
      st_n  = DRAIN;
      idx_n = '0;
      lst_n = s_last;
    end else if (fire && at_end) begin
      st_n = IDLE;
    end else if (fire) begin
      idx_n = idx + 1'b1;
    end
  end

  always_comb begin
    m_valid = (st == DRAIN);
    m_data  = obuf[idx];
    m_last  = m_valid && lst && (idx == LAST);
    s_ready = (st == IDLE) ||
              (m_valid && m_ready && (idx == LAST));
  end

endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: directed vectors for acc_drain with
// hand-computed requantized lane values.
module tb_acc_drain;

  localparam int R     = 8;
  localparam int WY    = 16;
  localparam int WO    = 8;
  localparam int SHIFT = 4;

  logic                 clk;
  logic                 rstn;
  logic                 s_valid;
  logic                 s_ready;
  logic [R*WY-1:0]      s_data;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [WO-1:0] m_data;
  logic                 m_last;

  int nvec;
  int nbad;

  acc_drain #(
    .R(R), .WY(WY), .WO(WO), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d, want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [R*WY-1:0] pack(
    input int a[R]
  );
    logic [R*WY-1:0] d;
    int x;
    d = '0;
    for (int i = 0; i < R; i++) begin
      x = a[i];
      d[i*WY +: WY] = x[WY-1:0];
    end
    return d;
  endfunction

  // Lane i holds (base+i)*16, which requantizes to base+i.
  function automatic logic [R*WY-1:0] mk(input int base);
    int a[R];
    for (int i = 0; i < R; i++)
      a[i] = (base + i) * 16;
    return pack(a);
  endfunction

  task automatic run_vec(input string tag,
                         input int a[R],
                         input int e[R]);
    s_data  = pack(a);
    s_last  = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    #1 chk({tag, "_srdy"}, int'(s_ready), 1);
    cyc();
    s_valid = 1'b0;
    for (int i = 0; i < R; i++) begin
      #1;
      chk({tag, "_vld"}, int'(m_valid), 1);
      chk({tag, "_dat"}, int'(m_data), e[i]);
      chk({tag, "_lst"}, int'(m_last), 0);
      cyc();
    end
    #1 chk({tag, "_end"}, int'(m_valid), 0);
  endtask

  int rnd_in[R]  = '{8, 7, -8, -9, 24, 0, 15, 16};
  int rnd_ex[R]  = '{1, 0, 0, -1, 2, 0, 1, 1};
  int sat_in[R]  = '{32767, -32768, 2040, 2039,
                     -2056, -2057, 0, 0};
  int sat_ex[R]  = '{127, -128, 127, 127,
                     -128, -128, 0, 0};

  initial begin
    int  got;
    int  prev;
    bit  stl;
    int  beats;
    int  caps;
    bit  cp;

    nvec    = 0;
    nbad    = 0;
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (2) cyc();
    #1;
    chk("rst_vld", int'(m_valid), 0);
    chk("rst_dat", int'(m_data), 0);
    chk("rst_lst", int'(m_last), 0);
    chk("rst_srdy", int'(s_ready), 1);
    cyc();
    rstn = 1'b1;
    cyc();

    run_vec("rnd", rnd_in, rnd_ex);
    cyc();
    run_vec("sat", sat_in, sat_ex);
    cyc();

    // Backpressure with m_ready pattern 1,0,0,1
    s_data  = mk(0);
    s_last  = 1'b0;
    s_valid = 1'b1;
    cyc();
    s_valid = 1'b0;
    got = 0;
    stl = 1'b0;
    prev = 0;
    for (int c = 0; c < 60 && got < R; c++) begin
      m_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      chk("bp_vld", int'(m_valid), 1);
      chk("bp_srdy", int'(s_ready),
          int'(m_ready && got == R - 1));
      if (stl)
        chk("bp_hold", int'(m_data), prev);
      if (m_ready) begin
        chk("bp_dat", int'(m_data), got);
        got++;
        stl = 1'b0;
      end else begin
        prev = int'(m_data);
        stl = 1'b1;
      end
      cyc();
    end
    chk("bp_cnt", got, R);
    m_ready = 1'b1;
    #1 chk("bp_end", int'(m_valid), 0);
    cyc();

    // Back-to-back: three vectors, s_valid held high
    s_data  = mk(0);
    s_last  = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    beats = 0;
    caps  = 0;
    for (int c = 0; c < 40 && beats < 3*R; c++) begin
      #1;
      cp = s_valid && s_ready;
      if (m_valid) begin
        beats++;
        chk("b2b_dat", int'(m_data), beats - 1);
        chk("b2b_last", int'(m_last),
            int'(beats == 3*R));
      end else if (beats > 0) begin
        chk("b2b_gap", int'(m_valid), 1);
      end
      cyc();
      if (cp) begin
        caps++;
        if (caps < 3) begin
          s_data = mk(caps * R);
          s_last = (caps == 2);
        end else begin
          s_valid = 1'b0;
        end
      end
    end
    chk("b2b_beats", beats, 3*R);
    chk("b2b_caps", caps, 3);
    s_valid = 1'b0;
    s_last  = 1'b0;
    cyc();
    #1 chk("b2b_end", int'(m_valid), 0);
    cyc();

    // Final-lane stall while a new vector waits
    s_data  = mk(0);
    s_valid = 1'b1;
    m_ready = 1'b1;
    cyc();
    s_data = mk(R);
    s_last = 1'b1;
    for (int i = 0; i < R - 1; i++) begin
      #1 chk("ov_dat", int'(m_data), i);
      cyc();
    end
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ov_sdat", int'(m_data), R - 1);
      chk("ov_srdy", int'(s_ready), 0);
      chk("ov_svld", int'(m_valid), 1);
      cyc();
    end
    m_ready = 1'b1;
    #1;
    chk("ov_rrdy", int'(s_ready), 1);
    chk("ov_rlst", int'(m_last), 0);
    cyc();
    s_valid = 1'b0;
    s_last  = 1'b0;
    for (int i = 0; i < R; i++) begin
      #1;
      chk("ov_nvld", int'(m_valid), 1);
      chk("ov_ndat", int'(m_data), R + i);
      chk("ov_nlst", int'(m_last), int'(i == R - 1));
      cyc();
    end
    #1 chk("ov_end", int'(m_valid), 0);
    cyc();

    // Asynchronous reset mid-drain at lane 3
    s_data  = mk(0);
    s_valid = 1'b1;
    m_ready = 1'b1;
    cyc();
    s_valid = 1'b0;
    repeat (3) cyc();
    #1 chk("mr_pre", int'(m_data), 3);
    #1 rstn = 1'b0;
    #1;
    chk("mr_vld", int'(m_valid), 0);
    chk("mr_dat", int'(m_data), 0);
    chk("mr_lst", int'(m_last), 0);
    cyc();
    rstn = 1'b1;
    #1 chk("mr_srdy", int'(s_ready), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1 chk("mr_quiet", int'(m_valid), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
